// File: rtl/daq_pkg.sv
// Shared types and defaults for the DAQ sweep/acquisition path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package daq_pkg;

  // Default converter widths
  localparam int DAC_W = 12;
  localparam int ADC_W = 12;

  // Sweep sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_DAC,
    ST_SETTLE,
    ST_ADC_GO,
    ST_WAIT_ADC,
    ST_EMIT,
    ST_NEXT
  } sweep_state_t;

  // Reset values
  localparam sweep_state_t STATE_RST  = ST_IDLE;
  localparam logic         STROBE_RST = 1'b0;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that flags when the settling interval has elapsed.
// Latency: zero_o reflects the registered count; load/decrement take effect next cycle.
// Backpressure: none; the counter saturates at zero.
module settle_timer #(
  parameter int SetW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [SetW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [SetW-1:0] cnt_q;

  // Load has priority; decrement stops at zero so a late dec never wraps
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - SetW'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sweep_avg_ctrl.sv
// DAC sweep sequencer: per point write DAC, settle, burst-sample ADC, average, emit (code, avg).
// Latency: start->stdac 1 cycle; eodac->stadc kset+2; last eoadc->res_valid 1; transfer->next stdac 2.
// Backpressure: res_valid/res_ready; EMIT holds result and issues no strobes until accepted.
// Build option SWEEP_AVG_EN: when defined, averages 2^NAvgLog2 samples per point; otherwise one sample.
module sweep_avg_ctrl
  import daq_pkg::*;
#(
  parameter int DacW     = DAC_W,
  parameter int AdcW     = ADC_W,
  parameter int NAvgLog2 = 2,
  parameter int SetW     = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [DacW-1:0] code_start_i,
  input  logic [DacW-1:0] code_stop_i,
  input  logic [DacW-1:0] step_i,
  input  logic [SetW-1:0] kset_i,
  output logic            stdac_o,
  output logic [DacW-1:0] din_dac_o,
  input  logic            eodac_i,
  output logic            stadc_o,
  input  logic            eoadc_i,
  input  logic [AdcW-1:0] dadc_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [DacW-1:0] res_code_o,
  output logic [AdcW-1:0] res_data_o,
  output logic            busy_o,
  output logic            eos_o
);

  sweep_state_t    state_q, state_d;
  logic [DacW-1:0] code_q, code_d;
  logic [DacW-1:0] stop_q, step_q;
  logic [SetW-1:0] kset_q;
  logic            abort_q, abort_any;
  logic [DacW:0]   sum;
  logic            last_pt;
  logic            eos_d;
  logic            settle_zero;
  logic            last_smp;
  logic [AdcW-1:0] res_data_d;

  assign abort_any = abort_q | abort_i;

  // One extra bit so a step past the top of the DAC range is seen as overflow, not a wrap
  assign sum     = {1'b0, code_q} + {1'b0, step_q};
  assign last_pt = (step_q == '0) || (sum > {1'b0, stop_q});

  settle_timer #(.SetW(SetW)) u_settle (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     ((state_q == ST_WAIT_DAC) && eodac_i),
    .load_val_i (kset_q),
    .dec_i      (state_q == ST_SETTLE),
    .zero_o     (settle_zero)
  );

`ifdef SWEEP_AVG_EN
  localparam int AccW = AdcW + NAvgLog2;

  logic [AccW-1:0]     acc_q, acc_sum;
  logic [NAvgLog2-1:0] smp_q;

  assign acc_sum    = acc_q + AccW'(dadc_i);
  assign last_smp   = (smp_q == {NAvgLog2{1'b1}});
  assign res_data_d = acc_sum[AccW-1:NAvgLog2];

  // Accumulate each conversion; both clear as a new point starts
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q <= '0;
      smp_q <= '0;
    end else if (state_d == ST_LOAD) begin
      acc_q <= '0;
      smp_q <= '0;
    end else if ((state_q == ST_WAIT_ADC) && eoadc_i) begin
      acc_q <= acc_sum;
      smp_q <= smp_q + NAvgLog2'(1);
    end
  end
`else
  // Single conversion per point: the sample is the result
  assign last_smp   = 1'b1;
  assign res_data_d = dadc_i;

  // NAvgLog2 is accepted for interface compatibility but has no effect here
  if (NAvgLog2 < 0) begin : g_navg_unused
  end
`endif

  // Next-state and next-code decode; abort wins wherever no SPI transfer is in flight
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    eos_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          code_d  = code_start_i;
        end
      end
      ST_LOAD:     state_d = abort_any ? ST_IDLE : ST_WAIT_DAC;
      ST_WAIT_DAC: begin
        if (eodac_i) state_d = abort_any ? ST_IDLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort_any)        state_d = ST_IDLE;
        else if (settle_zero) state_d = ST_ADC_GO;
      end
      ST_ADC_GO:   state_d = abort_any ? ST_IDLE : ST_WAIT_ADC;
      ST_WAIT_ADC: begin
        if (eoadc_i) begin
          if (abort_any)     state_d = ST_IDLE;
          else if (last_smp) state_d = ST_EMIT;
          else               state_d = ST_ADC_GO;
        end
      end
      ST_EMIT: begin
        if (abort_any)        state_d = ST_IDLE;
        else if (res_ready_i) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (abort_any) begin
          state_d = ST_IDLE;
        end else if (last_pt) begin
          state_d = ST_IDLE;
          eos_d   = 1'b1;
        end else begin
          state_d = ST_LOAD;
          code_d  = sum[DacW-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, current code and the pending-abort flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= STATE_RST;
      code_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      abort_q <= (state_d == ST_IDLE) ? 1'b0 : abort_any;
    end
  end

  // Sweep parameters are captured once so the caller may change them mid-sweep
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stop_q <= '0;
      step_q <= '0;
      kset_q <= '0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      stop_q <= code_stop_i;
      step_q <= step_i;
      kset_q <= kset_i;
    end
  end

  // Strobes and status decoded from the next state so they line up with the state they describe
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stdac_o     <= STROBE_RST;
      stadc_o     <= STROBE_RST;
      res_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      eos_o       <= 1'b0;
    end else begin
      stdac_o     <= (state_d == ST_LOAD);
      stadc_o     <= (state_d == ST_ADC_GO);
      res_valid_o <= (state_d == ST_EMIT);
      busy_o      <= (state_d != ST_IDLE);
      eos_o       <= eos_d;
    end
  end

  // Data outputs only change on entry to LOAD / EMIT, so they are stable while presented
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      din_dac_o  <= '0;
      res_code_o <= '0;
      res_data_o <= '0;
    end else begin
      if (state_d == ST_LOAD) din_dac_o <= code_d;
      if ((state_q == ST_WAIT_ADC) && (state_d == ST_EMIT)) begin
        res_code_o <= code_q;
        res_data_o <= res_data_d;
      end
    end
  end

endmodule
